// File: rtl/tcm_image_loader.sv
`default_nettype none
// ============================================================================
// Module      : tcm_image_loader
// Description : Boot-image loader. Packs a valid/ready byte stream into
//               DATA_W-bit words, writes them to the selected TCM channels
//               through an SRAM write port, optionally zero-fills the rest
//               of the memory and holds the core in reset until complete.
// Revision    : 1.0 - initial release
// ============================================================================
module tcm_image_loader #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned NUM_CH         = 2,
    parameter bit          FIRST_BYTE_LSB = 1'b1,
    parameter bit          ZERO_FILL      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_words_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_rdy_o,
    output logic [NUM_CH-1:0] ram_cs_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic              ram_rdy_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              core_rst_n_o
);

    localparam int unsigned         c_BYTES     = DATA_W / 8;
    localparam int unsigned         c_IDX_W     = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(c_BYTES - 1);
    localparam logic [ADDR_W+1:0]   c_DEPTH     = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_COLLECT = 3'd2,
        S_WRITE   = 3'd3,
        S_FILL    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   cur_q;
    logic [ADDR_W:0]     word_cnt_q;
    logic [c_IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0]   pack_q;
    logic [DATA_W-1:0]   pack_d;

    logic                byte_rdy_q;
    logic [NUM_CH-1:0]   ram_cs_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                core_rst_n_q;

    logic [c_IDX_W-1:0]  w_byte_pos;
    logic [ADDR_W+1:0]   w_end;
    logic                w_range_err;
    logic                w_take;
    logic [ADDR_W-1:0]   w_cur_next;
    logic [ADDR_W:0]     w_cnt_next;

    // Byte lane that the current stream byte lands in
    generate
        if (FIRST_BYTE_LSB) begin : g_lsb_first
            assign w_byte_pos = idx_q;
        end else begin : g_msb_first
            assign w_byte_pos = c_LAST_IDX - idx_q;
        end
    endgenerate

    assign w_end       = {2'b00, base_q} + {1'b0, len_q};
    assign w_range_err = (w_end > c_DEPTH) || (mask_q == '0);
    assign w_take      = byte_vld_i & byte_rdy_q;
    assign w_cur_next  = cur_q + ADDR_W'(1);
    assign w_cnt_next  = word_cnt_q + (ADDR_W+1)'(1);

    // Pack register with the incoming byte merged into its lane
    always_comb begin
        pack_d = pack_q;
        pack_d[{w_byte_pos, 3'b000} +: 8] = byte_data_i;
    end

    // Load sequencer; every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            base_q       <= '0;
            len_q        <= '0;
            cur_q        <= '0;
            word_cnt_q   <= '0;
            idx_q        <= '0;
            pack_q       <= '0;
            byte_rdy_q   <= 1'b0;
            ram_cs_q     <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        mask_q       <= ch_mask_i;
                        base_q       <= base_addr_i;
                        len_q        <= len_words_i;
                        err_q        <= 1'b0;
                        done_q       <= 1'b0;
                        core_rst_n_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    cur_q      <= base_q;
                    word_cnt_q <= '0;
                    idx_q      <= '0;
                    if (w_range_err) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (len_q == '0) begin
                        if (ZERO_FILL) begin
                            ram_cs_q    <= mask_q;
                            ram_we_q    <= 1'b1;
                            ram_addr_q  <= base_q;
                            ram_wdata_q <= '0;
                            state_q     <= S_FILL;
                        end else begin
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                            state_q      <= S_DONE;
                        end
                    end else begin
                        byte_rdy_q <= 1'b1;
                        state_q    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_take) begin
                        pack_q <= pack_d;
                        if (idx_q == c_LAST_IDX) begin
                            idx_q       <= '0;
                            byte_rdy_q  <= 1'b0;
                            ram_cs_q    <= mask_q;
                            ram_we_q    <= 1'b1;
                            ram_addr_q  <= cur_q;
                            ram_wdata_q <= pack_d;
                            state_q     <= S_WRITE;
                        end else begin
                            idx_q <= idx_q + c_IDX_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (ram_rdy_i) begin
                        cur_q      <= w_cur_next;
                        word_cnt_q <= w_cnt_next;
                        if (w_cnt_next == len_q) begin
                            if (ZERO_FILL && (cur_q != c_LAST_ADDR)) begin
                                ram_addr_q  <= w_cur_next;
                                ram_wdata_q <= '0;
                                state_q     <= S_FILL;
                            end else begin
                                ram_cs_q     <= '0;
                                ram_we_q     <= 1'b0;
                                busy_q       <= 1'b0;
                                done_q       <= 1'b1;
                                core_rst_n_q <= 1'b1;
                                state_q      <= S_DONE;
                            end
                        end else begin
                            ram_cs_q   <= '0;
                            ram_we_q   <= 1'b0;
                            byte_rdy_q <= 1'b1;
                            state_q    <= S_COLLECT;
                        end
                    end
                end
                S_FILL: begin
                    if (ram_rdy_i) begin
                        if (cur_q == c_LAST_ADDR) begin
                            ram_cs_q     <= '0;
                            ram_we_q     <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            cur_q      <= w_cur_next;
                            ram_addr_q <= w_cur_next;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_rdy_o   = byte_rdy_q;
    assign ram_cs_o     = ram_cs_q;
    assign ram_we_o     = ram_we_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign core_rst_n_o = core_rst_n_q;

endmodule
`default_nettype wire
